sine_wave_gen: RTL and testbench



---
 rtl/sine_wave_gen.sv | 53 +++++
 tb/tb_sine_wave_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/sine_wave_gen.sv
// Phase-to-amplitude converter: 6-bit phase index -> 16-bit signed sine sample, one register stage.
// Build option SINE_FULL_TABLE_EN selects a direct 64-entry table instead of quarter-wave folding.
module sine_wave_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  phase,
  output logic [15:0] out
);

  logic [15:0] sample;

`ifdef SINE_FULL_TABLE_EN
  localparam logic [15:0] FULL_TAB [64] = '{
     16'sd0,      16'sd3212,   16'sd6393,   16'sd9512,   16'sd12539,  16'sd15446,  16'sd18204,  16'sd20787,
     16'sd23170,  16'sd25329,  16'sd27245,  16'sd28898,  16'sd30273,  16'sd31356,  16'sd32137,  16'sd32609,
     16'sd32767,  16'sd32609,  16'sd32137,  16'sd31356,  16'sd30273,  16'sd28898,  16'sd27245,  16'sd25329,
     16'sd23170,  16'sd20787,  16'sd18204,  16'sd15446,  16'sd12539,  16'sd9512,   16'sd6393,   16'sd3212,
     16'sd0,     -16'sd3212,  -16'sd6393,  -16'sd9512,  -16'sd12539, -16'sd15446, -16'sd18204, -16'sd20787,
    -16'sd23170, -16'sd25329, -16'sd27245, -16'sd28898, -16'sd30273, -16'sd31356, -16'sd32137, -16'sd32609,
    -16'sd32767, -16'sd32609, -16'sd32137, -16'sd31356, -16'sd30273, -16'sd28898, -16'sd27245, -16'sd25329,
    -16'sd23170, -16'sd20787, -16'sd18204, -16'sd15446, -16'sd12539, -16'sd9512,  -16'sd6393,  -16'sd3212
  };

  always_comb begin
    sample = FULL_TAB[phase];
  end
`else
  localparam logic [15:0] QTAB [17] = '{
    16'd0,     16'd3212,  16'd6393,  16'd9512,  16'd12539, 16'd15446,
    16'd18204, 16'd20787, 16'd23170, 16'd25329, 16'd27245, 16'd28898,
    16'd30273, 16'd31356, 16'd32137, 16'd32609, 16'd32767
  };

  logic [4:0]  qidx;
  logic [15:0] mag;

  // Odd quadrants read the quarter table backwards; the lower half of the period is negated.
  always_comb begin
    qidx   = phase[4] ? (5'd16 - {1'b0, phase[3:0]}) : {1'b0, phase[3:0]};
    mag    = QTAB[qidx];
    sample = phase[5] ? (~mag + 16'd1) : mag;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= sample;
    end
  end

endmodule

// File: tb/tb_sine_wave_gen.sv
// Directed bench for sine_wave_gen: reset, cardinal points, full sweep with wrap, symmetry, QPSK jumps.
module tb_sine_wave_gen;

  logic        clk;
  logic        rst_n;
  logic [5:0]  phase;
  logic [15:0] out;

  int checks = 0;
  int errors = 0;
  int trace [64];

  int exp_tab [64] = '{
         0,   3212,   6393,   9512,  12539,  15446,  18204,  20787,
     23170,  25329,  27245,  28898,  30273,  31356,  32137,  32609,
     32767,  32609,  32137,  31356,  30273,  28898,  27245,  25329,
     23170,  20787,  18204,  15446,  12539,   9512,   6393,   3212,
         0,  -3212,  -6393,  -9512, -12539, -15446, -18204, -20787,
    -23170, -25329, -27245, -28898, -30273, -31356, -32137, -32609,
    -32767, -32609, -32137, -31356, -30273, -28898, -27245, -25329,
    -23170, -20787, -18204, -15446, -12539,  -9512,  -6393,  -3212
  };

  sine_wave_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase),
    .out   (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int out_val();
    return int'($signed(out));
  endfunction

  // Apply a phase, let one edge capture it, then sample 1 time unit later.
  task automatic step(input logic [5:0] p, output int val);
    phase = p;
    @(posedge clk);
    #1;
    val = out_val();
  endtask

  initial begin
    int v;
    int cnt8000;
    rst_n = 1'b1;
    phase = 6'd16;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", out_val(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", out_val(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release_p16", out_val(), 32767);
    chk("reset_release_hex", int'(out), 32'h7FFF);

    step(6'd0,  v); chk("card_0",  v, 0);
    step(6'd16, v); chk("card_16", v, 32767);
    step(6'd32, v); chk("card_32", v, 0);
    step(6'd48, v); chk("card_48", v, -32767);
    chk("card_48_hex", int'(out), 32'h8001);

    // Reset mid-stream: must clear immediately and come back straight to a valid sample.
    step(6'd8, v); chk("pre_reset_8", v, 23170);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", out_val(), 0);
    phase = 6'd40;
    @(posedge clk);
    #1;
    chk("midreset_hold", out_val(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_release_40", out_val(), -23170);

    for (int k = 0; k < 64; k++) begin
      step(6'(k), v);
      trace[k] = v;
      chk($sformatf("sweep_%0d", k), v, exp_tab[k]);
    end
    step(6'd0, v); chk("wrap_0", v, 0);
    chk("spot_1",  trace[1],  3212);
    chk("spot_8",  trace[8],  32'sh5A82);
    chk("spot_40", trace[40] & 32'hFFFF, 32'hA57E);
    chk("spot_63", trace[63] & 32'hFFFF, 32'hF374);

    cnt8000 = 0;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("sym_neg_%0d", k), trace[k] + trace[(k + 32) % 64], 0);
      chk($sformatf("sym_mir_%0d", k), trace[k], trace[(96 - k) % 64]);
      if (trace[k] == -32768) cnt8000++;
    end
    chk("no_0x8000", cnt8000, 0);

    step(6'd5,  v); chk("jump_5",  v, 15446);
    step(6'd21, v); chk("jump_21", v, 28898);
    step(6'd37, v); chk("jump_37", v, -15446);
    step(6'd53, v); chk("jump_53", v, -28898);
    step(6'd63, v); chk("jump_63", v, -3212);
    step(6'd31, v); chk("jump_31", v, 3212);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
